// File: rtl/axis_fifo_deser_if.sv
// Stream/status bundle for axis_fifo_deser: narrow upstream side, FIFO status, wide downstream side.
// slave is the converter's view, master is the surrounding system's view.
interface axis_fifo_deser_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_NB    = 2
);
    logic [DATA_WIDTH-1:0]         up_data;
    logic                          up_last;
    logic                          up_valid;
    logic                          up_ready;
    logic [ADDR_WIDTH:0]           count;
    logic                          empty;
    logic                          empty_a;
    logic                          full;
    logic                          full_a;
    logic [DATA_NB*DATA_WIDTH-1:0] down_data;
    logic                          down_valid;
    logic                          down_last;
    logic                          down_ready;

    modport slave (
        input  up_data, up_last, up_valid, down_ready,
        output up_ready, count, empty, empty_a, full, full_a,
        output down_data, down_valid, down_last
    );

    modport master (
        output up_data, up_last, up_valid, down_ready,
        input  up_ready, count, empty, empty_a, full, full_a,
        input  down_data, down_valid, down_last
    );
endinterface

// File: rtl/axis_fifo_deser.sv
// Buffered narrow-to-wide stream converter: a 2^ADDR_WIDTH FIFO feeding a DATA_NB-word packer.
// Define AXIS_DESER_MSB_FIRST_EN to place the first word of each beat in the most significant lane.
module axis_fifo_deser #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_NB    = 2
) (
    input  logic             clk,
    input  logic             rst,
    axis_fifo_deser_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CW    = ADDR_WIDTH + 1;
    localparam int KW    = (DATA_NB > 1) ? $clog2(DATA_NB) : 1;
    localparam int BW    = DATA_NB * DATA_WIDTH;

    logic [DATA_WIDTH:0]   mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  empty_q, empty_d, empty_a_q, empty_a_d;
    logic                  full_q, full_d, full_a_q, full_a_d;
    logic                  push, pop;
    logic                  rd_valid_q, rd_valid_d;
    logic [DATA_WIDTH:0]   rd_word_q;
    logic [KW-1:0]         k_q, k_d;
    logic [BW-1:0]         acc_q, acc_d, lanes_new;
    logic                  dvalid_q, dvalid_d, dlast_q, dlast_d;
    logic [BW-1:0]         ddata_q, ddata_d;
    int                    lane;

    assign push = bus.up_valid & ~full_q;
    assign pop  = ~empty_q & bus.down_ready;

    // Occupancy and flags are all registered from the same next-count value.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + ADDR_WIDTH'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + ADDR_WIDTH'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CW'(1);
        end
        empty_d    = (count_d == '0);
        empty_a_d  = (count_d <= CW'(1));
        full_d     = (count_d == CW'(DEPTH));
        full_a_d   = (count_d >= CW'(DEPTH - 1));
        rd_valid_d = bus.down_ready ? pop : rd_valid_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            empty_q    <= 1'b1;
            empty_a_q  <= 1'b1;
            full_q     <= 1'b0;
            full_a_q   <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            empty_q    <= empty_d;
            empty_a_q  <= empty_a_d;
            full_q     <= full_d;
            full_a_q   <= full_a_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Storage has no reset so it can map onto block RAM; the read register gives 1-cycle latency.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= {bus.up_last, bus.up_data};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_word_q <= '0;
        end else if (pop) begin
            rd_word_q <= mem[rd_ptr_q];
        end
    end

    // Packer: everything holds while down_ready is low; acc_q is cleared per beat so unfilled lanes read 0.
    always_comb begin
`ifdef AXIS_DESER_MSB_FIRST_EN
        lane = DATA_NB - 1 - int'(k_q);
`else
        lane = int'(k_q);
`endif
        lanes_new = acc_q;
        lanes_new[lane*DATA_WIDTH +: DATA_WIDTH] = rd_word_q[DATA_WIDTH-1:0];
        k_d      = k_q;
        acc_d    = acc_q;
        dvalid_d = dvalid_q;
        ddata_d  = ddata_q;
        dlast_d  = dlast_q;
        if (bus.down_ready) begin
            dvalid_d = 1'b0;
            if (rd_valid_q) begin
                if ((k_q == KW'(DATA_NB - 1)) || rd_word_q[DATA_WIDTH]) begin
                    dvalid_d = 1'b1;
                    ddata_d  = lanes_new;
                    dlast_d  = rd_word_q[DATA_WIDTH];
                    k_d      = '0;
                    acc_d    = '0;
                end else begin
                    k_d   = k_q + KW'(1);
                    acc_d = lanes_new;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_q      <= '0;
            acc_q    <= '0;
            dvalid_q <= 1'b0;
            ddata_q  <= '0;
            dlast_q  <= 1'b0;
        end else begin
            k_q      <= k_d;
            acc_q    <= acc_d;
            dvalid_q <= dvalid_d;
            ddata_q  <= ddata_d;
            dlast_q  <= dlast_d;
        end
    end

    assign bus.up_ready   = ~full_q;
    assign bus.count      = count_q;
    assign bus.empty      = empty_q;
    assign bus.empty_a    = empty_a_q;
    assign bus.full       = full_q;
    assign bus.full_a     = full_a_q;
    assign bus.down_data  = ddata_q;
    assign bus.down_valid = dvalid_q;
    assign bus.down_last  = dlast_q;
endmodule

// File: tb/tb_axis_fifo_deser.sv
// Scoreboard bench for axis_fifo_deser: directed pushes queue expected beats, a monitor checks every transfer.
// Lane ordering follows AXIS_DESER_MSB_FIRST_EN when that macro is defined.
module tb_axis_fifo_deser;
    localparam int DW = 32;
    localparam int AW = 9;
    localparam int NB = 2;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   vecCount = 0;
    int   missCount = 0;
    logic [64:0] sb [$];
    logic [64:0] expBeat;
    logic        holdArmed = 1'b0;
    logic        prevReady, prevValid, prevLast;
    logic [63:0] prevData;
    int          c0, firstCyc, highCnt;

    axis_fifo_deser_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DATA_NB(NB)) bus ();

    axis_fifo_deser #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DATA_NB(NB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] beat(input logic [31:0] first, input logic [31:0] second);
`ifdef AXIS_DESER_MSB_FIRST_EN
        return {first, second};
`else
        return {second, first};
`endif
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        vecCount++;
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] data, input logic last);
        bus.up_data  = data;
        bus.up_last  = last;
        bus.up_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.up_valid = 1'b0;
        bus.up_last  = 1'b0;
    endtask

    task automatic expectBeat(input logic last, input logic [63:0] data);
        sb.push_back({last, data});
    endtask

    task automatic waitDrain(input int budget);
        int n = 0;
        while (sb.size() > 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        vecCount++;
        if (sb.size() > 0) begin
            missCount++;
            $display("[TB] FAIL drain_timeout: %0d beats pending, expected 0", sb.size());
            sb.delete();
        end
        repeat (4) @(negedge clk);
    endtask

    // Monitor: every transfer pops the scoreboard; a low down_ready cycle must leave outputs untouched.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst) begin
                holdArmed = 1'b0;
            end else begin
                if (holdArmed && !prevReady) begin
                    vecCount++;
                    if (bus.down_valid !== prevValid || bus.down_data !== prevData || bus.down_last !== prevLast) begin
                        missCount++;
                        $display("[TB] FAIL hold: got v=%0b d=%0h l=%0b, expected v=%0b d=%0h l=%0b",
                                 bus.down_valid, bus.down_data, bus.down_last, prevValid, prevData, prevLast);
                    end
                end
                if (bus.down_valid && bus.down_ready) begin
                    vecCount++;
                    if (sb.size() == 0) begin
                        missCount++;
                        $display("[TB] FAIL unexpected_beat: got d=%0h l=%0b, expected no beat", bus.down_data, bus.down_last);
                    end else begin
                        expBeat = sb.pop_front();
                        if ({bus.down_last, bus.down_data} !== expBeat) begin
                            missCount++;
                            $display("[TB] FAIL beat: got d=%0h l=%0b, expected d=%0h l=%0b",
                                     bus.down_data, bus.down_last, expBeat[63:0], expBeat[64]);
                        end
                    end
                end
                prevReady = bus.down_ready;
                prevValid = bus.down_valid;
                prevData  = bus.down_data;
                prevLast  = bus.down_last;
                holdArmed = 1'b1;
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("[TB] FAIL watchdog: time limit reached, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        bus.up_data    = '0;
        bus.up_last    = 1'b0;
        bus.up_valid   = 1'b0;
        bus.down_ready = 1'b0;
        rst            = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_count",   64'(bus.count), 64'd0);
        checkOutput("rst_empty",   64'(bus.empty), 64'd1);
        checkOutput("rst_empty_a", 64'(bus.empty_a), 64'd1);
        checkOutput("rst_full",    64'(bus.full), 64'd0);
        checkOutput("rst_full_a",  64'(bus.full_a), 64'd0);
        checkOutput("rst_up_rdy",  64'(bus.up_ready), 64'd1);
        checkOutput("rst_dvalid",  64'(bus.down_valid), 64'd0);
        checkOutput("rst_dlast",   64'(bus.down_last), 64'd0);
        checkOutput("rst_ddata",   bus.down_data, 64'd0);

        // Two-word beat and its latency: valid in cycle t+4 for exactly one cycle.
        @(posedge clk);
        #1 bus.down_ready = 1'b1;
        @(posedge clk);
        #1;
        c0 = cyc;
        expectBeat(1'b0, beat(32'h11111111, 32'h22222222));
        applyStimulus(32'h11111111, 1'b0);
        applyStimulus(32'h22222222, 1'b0);
        firstCyc = -1;
        highCnt  = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.down_valid) begin
                if (firstCyc < 0) firstCyc = cyc;
                highCnt++;
            end
        end
        checkOutput("lat_cycle", 64'(firstCyc), 64'(c0 + 4));
        checkOutput("lat_width", 64'(highCnt), 64'd1);
        waitDrain(20);

        // Last flag closes a partial beat.
        expectBeat(1'b0, beat(32'h0000000A, 32'h0000000B));
        expectBeat(1'b1, beat(32'h0000000C, 32'h00000000));
        applyStimulus(32'h0000000A, 1'b0);
        applyStimulus(32'h0000000B, 1'b0);
        applyStimulus(32'h0000000C, 1'b1);
        waitDrain(50);

        // Fill to full with the consumer stalled, overflow once, then drain.
        bus.down_ready = 1'b0;
        for (int i = 0; i < 512; i++) begin
            applyStimulus(32'h10000000 + 32'(i), 1'b0);
            if (i == 0) begin
                checkOutput("one_count",   64'(bus.count), 64'd1);
                checkOutput("one_empty",   64'(bus.empty), 64'd0);
                checkOutput("one_empty_a", 64'(bus.empty_a), 64'd1);
            end
            if (i == 1) checkOutput("two_empty_a", 64'(bus.empty_a), 64'd0);
            if (i == 510) begin
                checkOutput("n1_full_a", 64'(bus.full_a), 64'd1);
                checkOutput("n1_full",   64'(bus.full), 64'd0);
            end
        end
        checkOutput("full_count", 64'(bus.count), 64'd512);
        checkOutput("full_full",  64'(bus.full), 64'd1);
        checkOutput("full_uprdy", 64'(bus.up_ready), 64'd0);
        applyStimulus(32'hDEADBEEF, 1'b0);
        checkOutput("ovf_count", 64'(bus.count), 64'd512);
        checkOutput("ovf_full",  64'(bus.full), 64'd1);
        for (int j = 0; j < 256; j++) begin
            expectBeat(1'b0, beat(32'h10000000 + 32'(2*j), 32'h10000000 + 32'(2*j + 1)));
        end
        bus.down_ready = 1'b1;
        waitDrain(1200);
        checkOutput("drain_count", 64'(bus.count), 64'd0);
        checkOutput("drain_empty", 64'(bus.empty), 64'd1);

        // down_ready toggling every cycle while 8 words stream in.
        for (int j = 0; j < 4; j++) begin
            expectBeat(1'b0, beat(32'h20 + 32'(2*j), 32'h20 + 32'(2*j + 1)));
        end
        fork
            begin
                for (int i = 0; i < 8; i++) applyStimulus(32'h20 + 32'(i), 1'b0);
            end
            begin
                repeat (24) begin
                    @(posedge clk);
                    #1 bus.down_ready = ~bus.down_ready;
                end
            end
        join
        bus.down_ready = 1'b1;
        waitDrain(100);

        // Reset with 5 words buffered drops them all.
        bus.down_ready = 1'b0;
        for (int i = 0; i < 5; i++) applyStimulus(32'h40 + 32'(i), 1'b0);
        checkOutput("pre_rst_count", 64'(bus.count), 64'd5);
        #2 rst = 1'b1;
        @(negedge clk);
        checkOutput("mid_rst_count",  64'(bus.count), 64'd0);
        checkOutput("mid_rst_dvalid", 64'(bus.down_valid), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_empty", 64'(bus.empty), 64'd1);
        checkOutput("post_rst_uprdy", 64'(bus.up_ready), 64'd1);
        @(posedge clk);
        #1 bus.down_ready = 1'b1;
        expectBeat(1'b0, beat(32'h55555555, 32'h66666666));
        applyStimulus(32'h55555555, 1'b0);
        applyStimulus(32'h66666666, 1'b0);
        waitDrain(20);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end
endmodule
